div_ppl_unit: RTL and testbench

- Parametrised pipelined integer divider for the EX stage. Implements RISC-V DIV/DIVU/REM/REMU with an internal restoring-division pipeline of configurable width and depth.
- Supports a pipeline stall, a flush, and a per-register busy scoreboard for the stall controller.
- Result goes to writeback with a valid strobe, STAGES cycles after issue.

---
 rtl/div_ppl_unit.sv | 183 ++++++++++++++++++
 tb/tb_div_ppl_unit.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/div_ppl_unit.sv
// div_ppl_unit: pipelined integer divider for the EX stage (DIV/DIVU/REM/REMU).
//
// A restoring divider is spread over STAGES register stages, each resolving
// XLEN/STAGES quotient bits. The first batch of iterations is done
// combinationally on the issue inputs, so a result is visible STAGES
// non-stalled edges after the issue edge (counting the issue edge itself).
//
// Ports:
//   clk, rst       clock and synchronous active-high reset
//   use_i          issue request
//   div_sign_i     1 = signed (DIV/REM), 0 = unsigned (DIVU/REMU)
//   div_result_i   0 = quotient, 1 = remainder
//   dividend       rs1 operand
//   divisor        rs2 operand
//   rd_addr_i      destination register of the presented operation
//   stall_i        freeze every pipeline register, no issue accepted
//   flush_i        kill in-flight and presented operations (beats stall_i)
//   valid_o        rd_addr/rd_data carry a completed result
//   rd_addr        destination of the completed result, 0 when idle
//   rd_data        completed result, 0 when idle
//   busy           at least one stage holds a live operation
//   rd_addr_flags  bit r set while register r is a pending destination
module div_ppl_unit #(
  parameter int XLEN   = 32,
  parameter int STAGES = 8,
  parameter int REG_AW = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 use_i,
  input  logic                 div_sign_i,
  input  logic                 div_result_i,
  input  logic [XLEN-1:0]      dividend,
  input  logic [XLEN-1:0]      divisor,
  input  logic [REG_AW-1:0]    rd_addr_i,
  input  logic                 stall_i,
  input  logic                 flush_i,
  output logic                 valid_o,
  output logic [REG_AW-1:0]    rd_addr,
  output logic [XLEN-1:0]      rd_data,
  output logic                 busy,
  output logic [2**REG_AW-1:0] rd_addr_flags
);

  localparam int STEP = XLEN / STAGES;

  typedef struct packed {
    logic              valid;
    logic [REG_AW-1:0] rd;
    logic              res_sel;   // 1 = remainder wanted
    logic              q_neg;     // quotient must be negated at the end
    logic              r_neg;     // remainder must be negated at the end
    logic              div0;
    logic              ovf;
    logic [XLEN-1:0]   dvd;       // original dividend, returned on div0
    logic [XLEN-1:0]   dvs;       // divisor magnitude
    logic [XLEN-1:0]   rem;       // partial remainder
    logic [XLEN-1:0]   quo;       // unconsumed dividend bits / quotient bits
  } stage_t;

  // STEP restoring iterations. The dividend magnitude is shifted out of the
  // top of quo while quotient bits are shifted in at the bottom, so after
  // XLEN iterations quo holds the full quotient.
  function automatic logic [2*XLEN-1:0] div_steps(
    input logic [XLEN-1:0] rem_in,
    input logic [XLEN-1:0] quo_in,
    input logic [XLEN-1:0] dvs_in
  );
    logic [XLEN:0]   trial;
    logic [XLEN-1:0] r;
    logic [XLEN-1:0] q;
    r = rem_in;
    q = quo_in;
    for (int i = 0; i < STEP; i++) begin
      trial = {r, q[XLEN-1]};
      q     = q << 1;
      if (trial >= {1'b0, dvs_in}) begin
        trial = trial - {1'b0, dvs_in};
        q[0]  = 1'b1;
      end
      r = trial[XLEN-1:0];
    end
    return {r, q};
  endfunction

  // Issue-side decode
  logic            accept;
  logic            a_neg;
  logic            b_neg;
  logic [XLEN-1:0] a_mag;
  logic [XLEN-1:0] b_mag;
  logic            div0_in;
  logic            ovf_in;

  assign accept  = use_i & ~stall_i & ~flush_i & (rd_addr_i != '0);
  assign a_neg   = div_sign_i & dividend[XLEN-1];
  assign b_neg   = div_sign_i & divisor[XLEN-1];
  assign a_mag   = a_neg ? -dividend : dividend;
  assign b_mag   = b_neg ? -divisor : divisor;
  assign div0_in = (divisor == '0);
  assign ovf_in  = div_sign_i & (dividend == {1'b1, {(XLEN-1){1'b0}}}) & (&divisor);

  stage_t stage_reg  [STAGES];
  stage_t stage_next [STAGES];

  for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
    stage_t src_w;

    if (gi == 0) begin : g_first
      always_comb begin
        src_w         = '0;
        src_w.valid   = accept;
        src_w.rd      = rd_addr_i;
        src_w.res_sel = div_result_i;
        src_w.q_neg   = a_neg ^ b_neg;
        src_w.r_neg   = a_neg;
        src_w.div0    = div0_in;
        src_w.ovf     = ovf_in;
        src_w.dvd     = dividend;
        src_w.dvs     = b_mag;
        src_w.rem     = '0;
        src_w.quo     = a_mag;
      end
    end else begin : g_rest
      assign src_w = stage_reg[gi-1];
    end

    always_comb begin
      stage_next[gi] = src_w;
      {stage_next[gi].rem, stage_next[gi].quo} = div_steps(src_w.rem, src_w.quo, src_w.dvs);
    end

    // Only the valid bit is reset; the datapath simply follows it.
    always_ff @(posedge clk) begin
      if (rst || flush_i) begin
        stage_reg[gi].valid <= 1'b0;
      end else if (!stall_i) begin
        stage_reg[gi] <= stage_next[gi];
      end
    end
  end

  // Result formatting from the last stage
  stage_t          last_w;
  logic [XLEN-1:0] q_fin;
  logic [XLEN-1:0] r_fin;

  assign last_w = stage_reg[STAGES-1];

  always_comb begin
    q_fin = last_w.q_neg ? -last_w.quo : last_w.quo;
    r_fin = last_w.r_neg ? -last_w.rem : last_w.rem;
    if (last_w.div0) begin
      q_fin = '1;
      r_fin = last_w.dvd;
    end else if (last_w.ovf) begin
      q_fin = {1'b1, {(XLEN-1){1'b0}}};
      r_fin = '0;
    end
  end

  assign valid_o = last_w.valid;
  assign rd_addr = last_w.valid ? last_w.rd : '0;
  assign rd_data = last_w.valid ? (last_w.res_sel ? r_fin : q_fin) : '0;

  // Scoreboard: pending destinations, including the one being presented so
  // the stall controller sees a dependency in the same cycle.
  always_comb begin
    busy          = 1'b0;
    rd_addr_flags = '0;
    for (int s = 0; s < STAGES; s++) begin
      if (stage_reg[s].valid) begin
        busy                             = 1'b1;
        rd_addr_flags[stage_reg[s].rd]   = 1'b1;
      end
    end
    if (use_i && !flush_i) begin
      rd_addr_flags[rd_addr_i] = 1'b1;
    end
    rd_addr_flags[0] = 1'b0;
  end

endmodule

// File: tb/tb_div_ppl_unit.sv
module tb_div_ppl_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        use_i = 1'b0;
  logic        div_sign_i = 1'b0;
  logic        div_result_i = 1'b0;
  logic [31:0] dividend = '0;
  logic [31:0] divisor = '0;
  logic [4:0]  rd_addr_i = '0;
  logic        stall_i = 1'b0;
  logic        flush_i = 1'b0;

  // index 0: STAGES=8 (directed), 1: STAGES=1, 2: STAGES=4, 3: STAGES=32
  logic        valid_a [4];
  logic [4:0]  rda_a   [4];
  logic [31:0] rdd_a   [4];
  logic        busy_a  [4];
  logic [31:0] flg_a   [4];

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  div_ppl_unit #(.XLEN(32), .STAGES(8), .REG_AW(5)) dut (
    .clk(clk), .rst(rst), .use_i(use_i), .div_sign_i(div_sign_i), .div_result_i(div_result_i),
    .dividend(dividend), .divisor(divisor), .rd_addr_i(rd_addr_i), .stall_i(stall_i), .flush_i(flush_i),
    .valid_o(valid_a[0]), .rd_addr(rda_a[0]), .rd_data(rdd_a[0]), .busy(busy_a[0]), .rd_addr_flags(flg_a[0]));

  div_ppl_unit #(.XLEN(32), .STAGES(1), .REG_AW(5)) dut1 (
    .clk(clk), .rst(rst), .use_i(use_i), .div_sign_i(div_sign_i), .div_result_i(div_result_i),
    .dividend(dividend), .divisor(divisor), .rd_addr_i(rd_addr_i), .stall_i(stall_i), .flush_i(flush_i),
    .valid_o(valid_a[1]), .rd_addr(rda_a[1]), .rd_data(rdd_a[1]), .busy(busy_a[1]), .rd_addr_flags(flg_a[1]));

  div_ppl_unit #(.XLEN(32), .STAGES(4), .REG_AW(5)) dut4 (
    .clk(clk), .rst(rst), .use_i(use_i), .div_sign_i(div_sign_i), .div_result_i(div_result_i),
    .dividend(dividend), .divisor(divisor), .rd_addr_i(rd_addr_i), .stall_i(stall_i), .flush_i(flush_i),
    .valid_o(valid_a[2]), .rd_addr(rda_a[2]), .rd_data(rdd_a[2]), .busy(busy_a[2]), .rd_addr_flags(flg_a[2]));

  div_ppl_unit #(.XLEN(32), .STAGES(32), .REG_AW(5)) dut32 (
    .clk(clk), .rst(rst), .use_i(use_i), .div_sign_i(div_sign_i), .div_result_i(div_result_i),
    .dividend(dividend), .divisor(divisor), .rd_addr_i(rd_addr_i), .stall_i(stall_i), .flush_i(flush_i),
    .valid_o(valid_a[3]), .rd_addr(rda_a[3]), .rd_data(rdd_a[3]), .busy(busy_a[3]), .rd_addr_flags(flg_a[3]));

  typedef struct {
    logic        sgn;
    logic        sel;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  rd;
    logic [31:0] exp;
  } vec_t;

  vec_t vt [16];
  logic [36:0] sbq [4][$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic sg, input logic sl, input logic [31:0] a,
                       input logic [31:0] b, input logic [4:0] rd);
    use_i = 1'b1; div_sign_i = sg; div_result_i = sl;
    dividend = a; divisor = b; rd_addr_i = rd;
  endtask

  task automatic idle();
    use_i = 1'b0; stall_i = 1'b0; flush_i = 1'b0;
  endtask

  // RISC-V division semantics, independent of the restoring algorithm
  function automatic logic [31:0] ref_div(input logic sg, input logic sl,
                                          input logic [31:0] a, input logic [31:0] b);
    if (b == 32'h0) return sl ? a : 32'hFFFF_FFFF;
    if (sg && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return sl ? 32'h0 : 32'h8000_0000;
    if (sg) return sl ? 32'($signed(a) % $signed(b)) : 32'($signed(a) / $signed(b));
    return sl ? a % b : a / b;
  endfunction

  task automatic run_vec(input int i);
    drive(vt[i].sgn, vt[i].sel, vt[i].a, vt[i].b, vt[i].rd);
    @(negedge clk);               // issue edge has passed
    idle();
    repeat (6) @(negedge clk);
    chk($sformatf("v%0d_early", i), valid_a[0], 1'b0);
    @(negedge clk);               // 8th edge
    chk($sformatf("v%0d_valid", i), valid_a[0], 1'b1);
    chk($sformatf("v%0d_rd", i), rda_a[0], vt[i].rd);
    chk($sformatf("v%0d_data", i), rdd_a[0], vt[i].exp);
    chk($sformatf("v%0d_flag", i), flg_a[0], 32'h1 << vt[i].rd);
    @(negedge clk);
    chk($sformatf("v%0d_gone", i), valid_a[0], 1'b0);
  endtask

  initial begin
    int n;
    int cnt;
    int r;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  rd;
    logic        sg;
    logic        sl;
    logic [36:0] e;

    vt[0]  = '{1'b1, 1'b0, 32'hFFFF_FFF9, 32'h2,         5'd5,  32'hFFFF_FFFD};
    vt[1]  = '{1'b1, 1'b1, 32'hFFFF_FFF9, 32'h2,         5'd5,  32'hFFFF_FFFF};
    vt[2]  = '{1'b0, 1'b0, 32'hFFFF_FFFF, 32'h10,        5'd7,  32'h0FFF_FFFF};
    vt[3]  = '{1'b0, 1'b1, 32'hFFFF_FFFF, 32'h10,        5'd7,  32'h0000_000F};
    vt[4]  = '{1'b1, 1'b0, 32'h1234,      32'h0,         5'd9,  32'hFFFF_FFFF};
    vt[5]  = '{1'b1, 1'b1, 32'h1234,      32'h0,         5'd9,  32'h0000_1234};
    vt[6]  = '{1'b0, 1'b0, 32'h1234,      32'h0,         5'd10, 32'hFFFF_FFFF};
    vt[7]  = '{1'b0, 1'b1, 32'h1234,      32'h0,         5'd10, 32'h0000_1234};
    vt[8]  = '{1'b1, 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 5'd31, 32'h8000_0000};
    vt[9]  = '{1'b1, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 5'd31, 32'h0000_0000};
    vt[10] = '{1'b1, 1'b0, 32'd100,       32'hFFFF_FFF9, 5'd1,  32'hFFFF_FFF2};
    vt[11] = '{1'b1, 1'b1, 32'd100,       32'hFFFF_FFF9, 5'd1,  32'h0000_0002};
    vt[12] = '{1'b1, 1'b0, 32'hFFFF_FF9C, 32'hFFFF_FFF9, 5'd2,  32'h0000_000E};
    vt[13] = '{1'b1, 1'b1, 32'hFFFF_FF9C, 32'hFFFF_FFF9, 5'd2,  32'hFFFF_FFFE};
    vt[14] = '{1'b0, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 5'd3,  32'h8000_0000};
    vt[15] = '{1'b1, 1'b1, 32'hFFFF_FFFB, 32'h0,         5'd4,  32'hFFFF_FFFB};

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_valid", valid_a[0], 1'b0);
    chk("rst_rd", rda_a[0], 5'd0);
    chk("rst_data", rdd_a[0], 32'h0);
    chk("rst_busy", busy_a[0], 1'b0);
    chk("rst_flags", flg_a[0], 32'h0);
    rst = 1'b0;

    for (int i = 0; i < 16; i++) begin
      run_vec(i);
    end

    // Back-to-back issue to rd=1..8
    for (int i = 1; i <= 8; i++) begin
      drive(1'b0, 1'b0, 32'(i * 1000 + 7), 32'(i + 1), 5'(i));
      @(negedge clk);
    end
    for (int k = 0; k < 8; k++) begin
      if (k == 1) idle();
      chk($sformatf("b2b%0d_valid", k), valid_a[0], 1'b1);
      chk($sformatf("b2b%0d_rd", k), rda_a[0], 5'(k + 1));
      chk($sformatf("b2b%0d_data", k), rdd_a[0], 32'(((k + 1) * 1000 + 7) / (k + 2)));
      chk($sformatf("b2b%0d_flags", k), flg_a[0], 32'h1FE & ~((32'h1 << (k + 1)) - 32'h2));
      if (k == 0) idle();
      @(negedge clk);
    end
    chk("b2b_end_valid", valid_a[0], 1'b0);
    chk("b2b_end_flags", flg_a[0], 32'h0);
    chk("b2b_end_busy", busy_a[0], 1'b0);

    // Stall three cycles mid-flight
    drive(1'b0, 1'b1, 32'd1000, 32'd3, 5'd6);
    @(negedge clk);
    idle();
    n = 1;
    repeat (2) begin @(negedge clk); n++; end
    stall_i = 1'b1;
    repeat (3) begin @(negedge clk); n++; end
    stall_i = 1'b0;
    while (!valid_a[0] && n < 40) begin @(negedge clk); n++; end
    chk("stall_latency", n, 11);
    chk("stall_data", rdd_a[0], 32'd1);
    chk("stall_rd", rda_a[0], 5'd6);
    @(negedge clk);

    // Stall while the result sits at the output
    drive(1'b0, 1'b0, 32'd1000, 32'd3, 5'd3);
    @(negedge clk);
    idle();
    n = 1;
    while (!valid_a[0] && n < 40) begin @(negedge clk); n++; end
    chk("hold_latency", n, 8);
    stall_i = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("hold_valid", valid_a[0], 1'b1);
      chk("hold_rd", rda_a[0], 5'd3);
      chk("hold_data", rdd_a[0], 32'd333);
      chk("hold_flags", flg_a[0], 32'h8);
      chk("hold_busy", busy_a[0], 1'b1);
    end
    stall_i = 1'b0;
    @(negedge clk);
    chk("hold_release", valid_a[0], 1'b0);

    // Flush together with stall
    for (int i = 1; i <= 3; i++) begin
      drive(1'b1, 1'b0, 32'd77, 32'd5, 5'(i));
      @(negedge clk);
    end
    drive(1'b1, 1'b0, 32'd77, 32'd5, 5'd4);
    stall_i = 1'b1;
    flush_i = 1'b1;
    @(negedge clk);
    chk("flush_busy", busy_a[0], 1'b0);
    chk("flush_valid", valid_a[0], 1'b0);
    chk("flush_flags", flg_a[0], 32'h0);
    idle();
    cnt = 0;
    repeat (12) begin @(negedge clk); if (valid_a[0]) cnt++; end
    chk("flush_noresult", cnt, 0);

    // Issue to x0
    drive(1'b0, 1'b0, 32'd100, 32'd3, 5'd0);
    #1;
    chk("rd0_flag", flg_a[0], 32'h0);
    @(negedge clk);
    idle();
    chk("rd0_busy", busy_a[0], 1'b0);
    cnt = 0;
    repeat (10) begin @(negedge clk); if (valid_a[0]) cnt++; end
    chk("rd0_noresult", cnt, 0);

    // Reset with four operations in flight
    for (int i = 1; i <= 4; i++) begin
      drive(1'b0, 1'b0, 32'd50, 32'd7, 5'(i));
      @(negedge clk);
    end
    idle();
    rst = 1'b1;
    @(negedge clk);
    chk("mrst_valid", valid_a[0], 1'b0);
    chk("mrst_rd", rda_a[0], 5'd0);
    chk("mrst_data", rdd_a[0], 32'h0);
    chk("mrst_busy", busy_a[0], 1'b0);
    chk("mrst_flags", flg_a[0], 32'h0);
    rst = 1'b0;
    cnt = 0;
    repeat (12) begin @(negedge clk); if (valid_a[0]) cnt++; end
    chk("mrst_noresult", cnt, 0);

    // Random traffic into all four depths, checked in issue order
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 3040; c++) begin
      for (int j = 0; j < 4; j++) begin
        if (valid_a[j]) begin
          if (sbq[j].size() == 0) begin
            total++;
            bad++;
            $display("FAIL sb_extra dut%0d: unexpected result rd=%0d data=0x%0h", j, rda_a[j], rdd_a[j]);
          end else begin
            e = sbq[j].pop_front();
            chk($sformatf("sb_dut%0d", j), {rda_a[j], rdd_a[j]}, e);
          end
        end
      end
      if (c < 3000 && $urandom_range(0, 3) != 0) begin
        r = $urandom_range(0, 7);
        a = (r == 0) ? 32'h8000_0000 : (r == 1) ? 32'($urandom_range(0, 20)) : $urandom;
        r = $urandom_range(0, 7);
        b = (r == 0) ? 32'h0 : (r == 1) ? 32'hFFFF_FFFF : (r == 2) ? 32'($urandom_range(1, 20)) :
            (r == 3) ? ($urandom & 32'hFFFF) : $urandom;
        sg = 1'($urandom);
        sl = 1'($urandom);
        rd = 5'($urandom);
        drive(sg, sl, a, b, rd);
        if (rd != 5'd0) begin
          for (int j = 0; j < 4; j++) sbq[j].push_back({rd, ref_div(sg, sl, a, b)});
        end
      end else begin
        idle();
      end
      @(negedge clk);
    end
    for (int j = 0; j < 4; j++) begin
      chk($sformatf("sb_left_dut%0d", j), sbq[j].size(), 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
